// File: rtl/bit_serial_pkg.sv
// bit_serial_pkg: shared state encoding and default word width for the bit-serial blocks
package bit_serial_pkg;
  localparam int DEF_WIDTH = 8;
  typedef enum logic {S_IDLE = 1'b0, S_SHIFT = 1'b1} state_t;
endpackage

// File: rtl/bit_serial_feeder_if.sv
// bit_serial_feeder_if: word handshake, bit strobe and serial output bundle
interface bit_serial_feeder_if import bit_serial_pkg::*; #(parameter int WIDTH = DEF_WIDTH);
  logic [WIDTH-1:0] in_data;
  logic in_valid;
  logic in_ready;
  logic bit_en;
  logic x_out;
  logic x_valid;
  logic busy;
  modport master(output in_data, in_valid, bit_en, input in_ready, x_out, x_valid, busy);
  modport slave(input in_data, in_valid, bit_en, output in_ready, x_out, x_valid, busy);
endinterface

// File: rtl/ser_hold_buf.sv
// ser_hold_buf: one-entry valid/ready holding register
module ser_hold_buf import bit_serial_pkg::*; #(parameter int WIDTH = DEF_WIDTH) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             wr_valid,
  output logic             wr_ready,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  input  logic             rd_take
);
  logic full;
  assign wr_ready = !full;
  assign rd_valid = full;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      full <= 1'b0;
      rd_data <= '0;
    end else if (wr_valid && !full) begin
      full <= 1'b1;
      rd_data <= wr_data;
    end else if (rd_take) full <= 1'b0;
endmodule

// File: rtl/bit_serial_feeder.sv
// bit_serial_feeder: parallel-to-serial front end with one-word lookahead buffer
module bit_serial_feeder import bit_serial_pkg::*; #(
  parameter int WIDTH     = DEF_WIDTH,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input logic clk,
  input logic rst,
  bit_serial_feeder_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  state_t state;
  logic [WIDTH-1:0] shreg, hold_data;
  logic [CW-1:0] bit_cnt;
  logic hold_full, hold_ready, xfer, last, take;
  assign last = bus.bit_en && bit_cnt == CW'(WIDTH - 1);
  assign xfer = bus.in_valid && hold_ready;
  assign take = state == S_SHIFT && last && hold_full;
  // Words go to the buffer only while a word is still shifting; otherwise they load shreg directly
  ser_hold_buf #(.WIDTH(WIDTH)) u_hold (
    .clk      (clk),
    .rst      (rst),
    .wr_data  (bus.in_data),
    .wr_valid (bus.in_valid && state == S_SHIFT && !last),
    .wr_ready (hold_ready),
    .rd_data  (hold_data),
    .rd_valid (hold_full),
    .rd_take  (take)
  );
  assign bus.in_ready = hold_ready;
  assign bus.x_valid = state == S_SHIFT;
  assign bus.x_out = state == S_SHIFT ? (MSB_FIRST ? shreg[WIDTH-1] : shreg[0]) : IDLE_BIT;
  assign bus.busy = state == S_SHIFT || hold_full;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= S_IDLE;
      shreg <= '0;
      bit_cnt <= '0;
    end else if (state == S_IDLE) begin
      if (xfer) begin
        shreg <= bus.in_data;
        bit_cnt <= '0;
        state <= S_SHIFT;
      end
    end else if (bus.bit_en) begin
      if (!last) begin
        shreg <= MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0} : {1'b0, shreg[WIDTH-1:1]};
        bit_cnt <= bit_cnt + 1'b1;
      end else if (hold_full) begin
        shreg <= hold_data;
        bit_cnt <= '0;
      end else if (xfer) begin
        shreg <= bus.in_data;
        bit_cnt <= '0;
      end else state <= S_IDLE;
    end
endmodule

// File: tb/tb_bit_serial_feeder.sv
// tb_bit_serial_feeder: queue-model scoreboard plus directed literal checks for two bit orders
module tb_bit_serial_feeder;
  import bit_serial_pkg::*;
  localparam int W = DEF_WIDTH;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  logic [W-1:0] in_data = '0;
  logic in_valid = 1'b0;
  logic bit_en = 1'b1;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit_serial_feeder_if #(.WIDTH(W)) m_if (), l_if ();
  assign m_if.in_data = in_data;
  assign m_if.in_valid = in_valid;
  assign m_if.bit_en = bit_en;
  assign l_if.in_data = in_data;
  assign l_if.in_valid = in_valid;
  assign l_if.bit_en = bit_en;
  bit_serial_feeder #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut_m (.clk(clk), .rst(rst), .bus(m_if));
  bit_serial_feeder #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) dut_l (.clk(clk), .rst(rst), .bus(l_if));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Model: accepted words wait in a queue; the front word's bits are consumed one per strobe
  logic [W-1:0] pend[$];
  bit cur_m[$];
  bit cur_l[$];
  logic [W-1:0] mw;
  bit acc;
  always @(posedge clk or negedge rst)
    if (!rst) begin
      pend.delete();
      cur_m.delete();
      cur_l.delete();
    end else begin
      acc = in_valid && pend.size() == 0;
      if (cur_m.size() != 0 && bit_en) begin
        void'(cur_m.pop_front());
        void'(cur_l.pop_front());
      end
      if (acc) pend.push_back(in_data);
      if (cur_m.size() == 0 && pend.size() != 0) begin
        mw = pend.pop_front();
        for (int i = 0; i < W; i++) begin
          cur_m.push_back(mw[W-1-i]);
          cur_l.push_back(mw[i]);
        end
      end
    end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    chk("m_x_valid", m_if.x_valid, cur_m.size() != 0);
    chk("m_x_out", m_if.x_out, cur_m.size() != 0 ? cur_m[0] : 1'b0);
    chk("m_in_ready", m_if.in_ready, pend.size() == 0);
    chk("m_busy", m_if.busy, cur_m.size() != 0 || pend.size() != 0);
    chk("l_x_valid", l_if.x_valid, cur_l.size() != 0);
    chk("l_x_out", l_if.x_out, cur_l.size() != 0 ? cur_l[0] : 1'b1);
    chk("l_in_ready", l_if.in_ready, pend.size() == 0);
    chk("l_busy", l_if.busy, cur_l.size() != 0 || pend.size() != 0);
  end

  logic lg_xm[1024];
  logic lg_xl[1024];
  logic lg_xv[1024];
  logic lg_ir[1024];
  always @(negedge clk) begin
    lg_xm[cyc & 1023] = m_if.x_out;
    lg_xl[cyc & 1023] = l_if.x_out;
    lg_xv[cyc & 1023] = m_if.x_valid;
    lg_ir[cyc & 1023] = m_if.in_ready;
  end

  function automatic int ix(input int c);
    return c & 1023;
  endfunction

  task automatic push(input logic [W-1:0] w, output int hs);
    int n;
    n = 0;
    hs = -1;
    in_data = w;
    in_valid = 1'b1;
    while (hs < 0 && n < 50) begin
      @(negedge clk);
      if (m_if.in_ready) begin
        @(posedge clk);
        #1;
        hs = cyc;
      end
      n++;
    end
    if (hs < 0) begin
      checks++;
      errors++;
      $display("FAIL push_timeout: word %0h not accepted within 50 cycles", w);
      hs = 0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int h, h2, r;
    logic [7:0] w8;
    logic [15:0] s16;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_x_valid", m_if.x_valid, 1'b0);
    chk("rst_x_out_m", m_if.x_out, 1'b0);
    chk("rst_x_out_l", l_if.x_out, 1'b1);
    chk("rst_busy", m_if.busy, 1'b0);
    chk("rst_in_ready", m_if.in_ready, 1'b1);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    // Single word MSB first, bit_en tied high
    w8 = 8'hE0;
    push(w8, h);
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("e0_pre_valid", lg_xv[ix(h-1)], 1'b0);
    for (int i = 0; i < 8; i++) begin
      chk("e0_bit", lg_xm[ix(h+i)], w8[7-i]);
      chk("e0_valid", lg_xv[ix(h+i)], 1'b1);
    end
    chk("e0_post_valid", lg_xv[ix(h+8)], 1'b0);
    // LSB-first instance
    w8 = 8'h07;
    push(w8, h);
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) chk("lsb_07_bit", lg_xl[ix(h+i)], i < 3);
    chk("lsb_idle_bit", lg_xl[ix(h+8)], 1'b1);
    // Back-to-back with in_valid held
    s16 = 16'hFF0F;
    push(8'hFF, h);
    push(8'h0F, h2);
    in_valid = 1'b0;
    chk("b2b_accept_cycle", h2 - h, 1);
    repeat (18) @(posedge clk);
    #1;
    for (int i = 0; i < 16; i++) begin
      chk("b2b_bit", lg_xm[ix(h+i)], s16[15-i]);
      chk("b2b_valid", lg_xv[ix(h+i)], 1'b1);
    end
    chk("b2b_post_valid", lg_xv[ix(h+16)], 1'b0);
    chk("b2b_ready_c2", lg_ir[ix(h+1)], 1'b0);
    chk("b2b_ready_c8", lg_ir[ix(h+7)], 1'b0);
    chk("b2b_ready_c9", lg_ir[ix(h+8)], 1'b1);
    // bit_en every third cycle
    w8 = 8'hA5;
    bit_en = 1'b0;
    push(w8, h);
    in_valid = 1'b0;
    for (int i = 0; i < 24; i++) begin
      bit_en = (i % 3 == 2);
      @(posedge clk);
      #1;
    end
    bit_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int j = 0; j < 24; j++) chk("slow_bit", lg_xm[ix(h+j)], w8[7-j/3]);
    chk("slow_post_valid", lg_xv[ix(h+24)], 1'b0);
    // Bypass: handshake lands on the last-bit strobe with the buffer empty
    s16 = 16'h3CC3;
    push(8'h3C, h);
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    push(8'hC3, h2);
    in_valid = 1'b0;
    chk("bypass_cycle", h2 - h, 8);
    repeat (10) @(posedge clk);
    #1;
    for (int i = 0; i < 16; i++) begin
      chk("bypass_bit", lg_xm[ix(h+i)], s16[15-i]);
      chk("bypass_valid", lg_xv[ix(h+i)], 1'b1);
    end
    chk("bypass_ready", lg_ir[ix(h+8)], 1'b1);
    // Async reset during the fourth bit
    push(8'hB7, h);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_x_valid", m_if.x_valid, 1'b0);
    chk("mid_rst_x_out_m", m_if.x_out, 1'b0);
    chk("mid_rst_x_out_l", l_if.x_out, 1'b1);
    chk("mid_rst_busy", m_if.busy, 1'b0);
    chk("mid_rst_in_ready", m_if.in_ready, 1'b1);
    @(negedge clk);
    #2;
    rst = 1'b1;
    r = cyc;
    repeat (12) @(posedge clk);
    #1;
    for (int i = 0; i < 10; i++) chk("post_rst_idle", lg_xv[ix(r+i)], 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
